muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Iterative RV32M multiply/divide unit with its own sequencing FSM. It sits beside the ALU in the EX stage.
- It accepts one M-extension operation per request and holds the pipeline through a stall output until the result is ready.
- It computes with a shift-add multiplier and a restoring divider, both sharing one WIDTH-bit adder/subtractor.
- It is the only multi-cycle EX resource, so the hazard logic ORs its stall into the IF/ID/EX stall.

Parameters:
- WIDTH, 32, operand/result width; must be even and at least 4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  EX holds a valid M-type instruction (opcode 0110011, Funct7 0000001)
- flush_i  in  1  EX being squashed (branch/jump redirect)
- funct3_i  in  3  M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a_i  in  WIDTH  rs1 value (dividend/multiplicand), forwarded
- op_b_i  in  WIDTH  rs2 value (divisor/multiplier), forwarded
- stall_o  out  1  freeze PC, IF/ID and ID/EX this cycle
- valid_o  out  1  one-cycle pulse: result_o is final
- result_o  out  WIDTH  result; held until the next accept

Behaviour:
- Reset (async, rst_n=0): state=IDLE, counter=0, valid_o=0, result_o=0, internal accumulators=0. A reset mid-operation discards the operation with no valid pulse.
- States and transitions:
  - IDLE: when start_i=1 and flush_i=0, latch operands, funct3 and sign info, then:
    - go to CALC, or
    - go to DONE directly for a special case.
  - CALC: one iteration per cycle, counter 0..WIDTH-1. Leave for FIXUP when counter==WIDTH-1.
  - FIXUP: one cycle. Apply the result sign negation and select hi/lo (mul) or quotient/remainder (div). Register result_o. Go to DONE.
  - DONE: valid_o=1, then go to IDLE.
- Latency: normal ops take WIDTH+2 cycles from the accept edge to the valid_o cycle (34 cycles at WIDTH=32). Special cases take 1 cycle.
- Special cases, decided in IDLE:
  - Divisor == 0: DIV/DIVU give all ones; REM/REMU give op_a.
  - Signed overflow (op_a = most negative value, op_b = -1): DIV gives op_a; REM gives 0.
- stall_o = (IDLE & start_i & ~flush_i) | CALC | FIXUP. It is combinational and low in DONE, so the pipeline advances exactly on the valid_o cycle.
- start_i in DONE is the same instruction leaving EX and is ignored. A new request is accepted only in IDLE.
- flush_i=1 in any state forces IDLE on the next edge with no valid_o. Flush has priority over start and over completion in DONE.
- Signed handling:
  - Operands are converted to magnitudes at accept.
  - Product sign = sign_a ^ sign_b for signed×signed; sign_a only for MULHSU.
  - Quotient sign = sign_a ^ sign_b.
  - Remainder sign = sign_a.
- Multiply: 2*WIDTH-bit product register. MUL returns the low half; MULH, MULHSU and MULHU return the high half.
- Divide: restoring, one quotient bit per cycle, remainder never negative after restore.

Decomposition:
- Shared package riscv_m_pkg:
  - enum mdv_state_t {IDLE, CALC, FIXUP, DONE}
  - funct3 constants F3_MUL..F3_REMU
  - constants OPC_RTYPE=7'b0110011 and F7_MULDIV=7'b0000001
- The ID-stage decoder uses the same constants to raise start_i, and the ALU controller uses them to exclude M ops.
- One sub-module, muldiv_datapath, holds the operand/accumulator registers and the shared adder/subtractor.
- muldiv_sequencer keeps the FSM, counter, stall and special-case logic.

Test Plan (WIDTH=32):
- MUL 7×(-3), start held -> stall_o high for 33 cycles; valid_o on cycle 34; result 0xFFFFFFEB.
- MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MULH with the same operands -> 0x00000000. MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Divide by zero: DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5. Overflow: DIV 0x80000000/-1 -> 0x80000000; REM 0x80000000/-1 -> 0. All four: valid_o one cycle after accept, stall_o high only in the accept cycle.
- flush_i pulsed at CALC counter=10 -> state IDLE next cycle, stall_o low, no valid_o. A following DIVU 9/3 returns 3 normally.
- rst_n dropped during CALC -> valid_o and result_o read 0 immediately (async). After release, back-to-back MUL 2×3 then MUL 4×5 with start_i held through DONE -> exactly two valid pulses, results 6 then 20.

Source files
------------

// File: rtl/riscv_m_pkg.sv
// Shared RV32M definitions: sequencer states, funct3 encodings and decode helpers.
// The ID decoder and ALU controller use the same opcode/funct7 constants.
package riscv_m_pkg;

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} mdv_state_t;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [6:0] OPC_RTYPE = 7'b0110011;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    function automatic logic a_is_signed(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
               (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic b_is_signed(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Operand/accumulator registers plus the single adder/subtractor shared by
// the shift-add multiplier and the restoring divider; also forms the fixed-up result.
module muldiv_datapath
    import riscv_m_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    output logic [WIDTH-1:0] fix_result_o
);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;

    logic [WIDTH-1:0]   mag_a, mag_b, acc_hi, acc_lo;
    logic [WIDTH:0]     add_a, add_b;
    logic [WIDTH+1:0]   sum_full;
    logic [2*WIDTH-1:0] mul_next, div_next, prod;
    logic [WIDTH-1:0]   quo, rem;
    logic               is_div, neg_res;

    assign is_div = op_i[2];
    assign acc_hi = acc_q[2*WIDTH-1:WIDTH];
    assign acc_lo = acc_q[WIDTH-1:0];

    assign sign_a_d = a_is_signed(op_i) & op_a_i[WIDTH-1];
    assign sign_b_d = b_is_signed(op_i) & op_b_i[WIDTH-1];
    assign mag_a    = sign_a_d ? -op_a_i : op_a_i;
    assign mag_b    = sign_b_d ? -op_b_i : op_b_i;

    // Divide compares the left-shifted partial remainder, which needs WIDTH+1 bits.
    assign add_a    = is_div ? acc_q[2*WIDTH-1:WIDTH-1] : {1'b0, acc_hi};
    assign add_b    = {1'b0, mcand_q};
    assign sum_full = is_div ? ({1'b0, add_a} - {1'b0, add_b})
                             : ({1'b0, add_a} + {1'b0, add_b});

    assign mul_next = acc_lo[0] ? {sum_full[WIDTH:0], acc_lo[WIDTH-1:1]}
                                : {1'b0, acc_hi, acc_lo[WIDTH-1:1]};
    assign div_next = sum_full[WIDTH+1] ? {add_a[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b0}
                                        : {sum_full[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b1};

    always_comb begin
        acc_d   = acc_q;
        mcand_d = mcand_q;
        if (load_i) begin
            mcand_d = is_div ? mag_b : mag_a;
            acc_d   = {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
        end else if (step_i) begin
            acc_d = is_div ? div_next : mul_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            if (load_i) begin
                sign_a_q <= sign_a_d;
                sign_b_q <= sign_b_d;
            end
        end
    end

    // Unsigned ops latch zero signs, so one rule covers every variant.
    assign neg_res = sign_a_q ^ sign_b_q;
    assign prod    = neg_res ? -acc_q : acc_q;
    assign quo     = neg_res ? -acc_lo : acc_lo;
    assign rem     = sign_a_q ? -acc_hi : acc_hi;

    always_comb begin
        fix_result_o = prod[WIDTH-1:0];
        case (op_i)
            F3_MUL:                        fix_result_o = prod[WIDTH-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  fix_result_o = prod[2*WIDTH-1:WIDTH];
            F3_DIV, F3_DIVU:               fix_result_o = quo;
            default:                       fix_result_o = rem;
        endcase
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit for EX: FSM, iteration counter,
// pipeline stall and the divide special cases resolved at accept.
module muldiv_sequencer
    import riscv_m_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             flush_i,
    input  logic [2:0]       funct3_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    output logic             stall_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o
);

    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    mdv_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic             accept, div_by_zero, overflow, special;
    logic [WIDTH-1:0] special_res, fix_result;
    logic [2:0]       dp_op;

    assign accept      = (state_q == IDLE) && start_i && !flush_i;
    assign div_by_zero = funct3_i[2] && (op_b_i == '0);
    assign overflow    = ((funct3_i == F3_DIV) || (funct3_i == F3_REM)) &&
                         (op_a_i == MIN_NEG) && (op_b_i == '1);
    assign special     = div_by_zero || overflow;
    // funct3[1] separates REM/REMU from DIV/DIVU.
    assign special_res = div_by_zero ? (funct3_i[1] ? op_a_i : '1)
                                     : (funct3_i[1] ? '0 : op_a_i);

    assign dp_op = (state_q == IDLE) ? funct3_i : op_q;

    muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_i       (accept),
        .step_i       (state_q == CALC),
        .op_i         (dp_op),
        .op_a_i       (op_a_i),
        .op_b_i       (op_b_i),
        .fix_result_o (fix_result)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d  = funct3_i;
                    cnt_d = '0;
                    if (special) begin
                        result_d = special_res;
                        state_d  = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) state_d = FIXUP;
            end
            FIXUP: begin
                result_d = fix_result;
                state_d  = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A squashed instruction must leave no trace, including in result_o.
        if (flush_i) begin
            state_d  = IDLE;
            cnt_d    = '0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            result_q <= result_d;
        end
    end

    assign stall_o  = accept || (state_q == CALC) || (state_q == FIXUP);
    assign valid_o  = (state_q == DONE) && !flush_i;
    assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed RV32M cases, flush/reset aborts
// and randomized operations checked against an arithmetic reference model.
module tb_muldiv_sequencer;

    localparam int W = 32;
    localparam logic [W-1:0] MIN_NEG = 32'h8000_0000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_i = 1'b0;
    logic         flush_i = 1'b0;
    logic [2:0]   funct3_i = 3'd0;
    logic [W-1:0] op_a_i = '0;
    logic [W-1:0] op_b_i = '0;
    logic         stall_o, valid_o;
    logic [W-1:0] result_o;

    int n_cmp = 0;
    int n_bad = 0;
    int n_valid = 0;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    logic [W-1:0] mon_exp;
    string        mon_name;

    always #5 clk = ~clk;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_i),
        .flush_i  (flush_i),
        .funct3_i (funct3_i),
        .op_a_i   (op_a_i),
        .op_b_i   (op_b_i),
        .stall_o  (stall_o),
        .valid_o  (valid_o),
        .result_o (result_o)
    );

    task automatic check(input string nm, input logic [W-1:0] got, input logic [W-1:0] req);
        n_cmp++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", nm, got, req);
        end
    endtask

    // Reference: RV32M semantics computed with 64-bit integer arithmetic.
    function automatic logic [W-1:0] ref_model(input logic [2:0] f3, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        longint     sa, sb, ua, ub;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        p  = '0;
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == '0) return '1;
                if (a == MIN_NEG && b == '1) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == '0) return '1;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == '0) return a;
                if (a == MIN_NEG && b == '1) return '0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == '0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f3, input logic [W-1:0] a,
                                      input logic [W-1:0] b);
        return f3[2] && ((b == '0) || (!f3[0] && a == MIN_NEG && b == '1));
    endfunction

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return MIN_NEG;
            3:       return W'($urandom_range(0, 15));
            default: return W'($urandom);
        endcase
    endfunction

    // Monitor: every valid_o pulse must match the oldest outstanding expectation.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (valid_o === 1'b1) begin
                n_valid++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_valid: got valid_o with result %h, required no pulse", result_o);
                end else begin
                    mon_exp  = exp_q.pop_front();
                    mon_name = name_q.pop_front();
                    check(mon_name, result_o, mon_exp);
                end
            end
        end
    end

    // Present one request, hold start_i through the valid cycle, check timing.
    task automatic run_op(input string nm, input logic [2:0] f3, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] req);
        int lat_exp, lat, stall_cnt;
        bit got;
        lat_exp = is_special(f3, a, b) ? 1 : W + 2;
        @(negedge clk);
        start_i  = 1'b1;
        funct3_i = f3;
        op_a_i   = a;
        op_b_i   = b;
        exp_q.push_back(req);
        name_q.push_back(nm);
        #1;
        check({nm, "_stall_accept"}, W'(stall_o), W'(1));
        lat = 0;
        stall_cnt = 0;
        got = 1'b0;
        for (int k = 1; k <= W + 8 && !got; k++) begin
            @(negedge clk);
            #1;
            if (valid_o) begin
                got = 1'b1;
                lat = k;
                check({nm, "_stall_done"}, W'(stall_o), W'(0));
            end else if (stall_o) begin
                stall_cnt++;
            end
        end
        check({nm, "_latency"}, W'(lat), W'(lat_exp));
        check({nm, "_stall_cycles"}, W'(stall_cnt), W'(lat_exp - 1));
        $display("op %s f3=%0d a=%h b=%h expect=%h latency=%0d", nm, f3, a, b, req, lat);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            start_i = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int v0;
        logic [2:0] f3;
        logic [W-1:0] a, b;

        #1;
        check("reset_valid", W'(valid_o), W'(0));
        check("reset_result", result_o, '0);
        check("reset_stall", W'(stall_o), W'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        run_op("mul_7x-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        idle(1);
        run_op("mulhu_ff", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        idle(1);
        run_op("mulh_ff", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
        idle(1);
        run_op("mulhsu_ff", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        idle(1);
        run_op("div_-7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        idle(1);
        run_op("rem_-7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        idle(1);
        run_op("divu_100/7", 3'd5, 32'd100, 32'd7, 32'd14);
        idle(1);
        run_op("remu_100/7", 3'd7, 32'd100, 32'd7, 32'd2);
        idle(1);
        run_op("div_5/0", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF);
        idle(1);
        run_op("rem_5/0", 3'd6, 32'd5, 32'd0, 32'd5);
        idle(1);
        run_op("div_ovf", 3'd4, MIN_NEG, 32'hFFFF_FFFF, MIN_NEG);
        idle(1);
        run_op("rem_ovf", 3'd6, MIN_NEG, 32'hFFFF_FFFF, 32'd0);
        idle(1);

        // Flush while CALC is on iteration 10: no result may appear.
        @(negedge clk);
        start_i  = 1'b1;
        funct3_i = 3'd5;
        op_a_i   = 32'hDEAD_BEEF;
        op_b_i   = 32'd7;
        repeat (11) @(negedge clk);
        #1;
        check("flush_stall_calc", W'(stall_o), W'(1));
        flush_i = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        flush_i = 1'b0;
        #1;
        check("flush_stall_after", W'(stall_o), W'(0));
        check("flush_valid_after", W'(valid_o), W'(0));
        idle(W + 4);
        run_op("divu_9/3", 3'd5, 32'd9, 32'd3, 32'd3);
        idle(1);

        // Asynchronous reset mid-CALC.
        @(negedge clk);
        start_i  = 1'b1;
        funct3_i = 3'd0;
        op_a_i   = 32'd7;
        op_b_i   = 32'd9;
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_valid", W'(valid_o), W'(0));
        check("rst_result", result_o, '0);
        start_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(W + 4);

        // Back-to-back with start_i held through DONE.
        v0 = n_valid;
        run_op("b2b_mul_2x3", 3'd0, 32'd2, 32'd3, 32'd6);
        run_op("b2b_mul_4x5", 3'd0, 32'd4, 32'd5, 32'd20);
        idle(W + 4);
        check("b2b_pulses", W'(n_valid - v0), W'(2));

        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            run_op("rand", f3, a, b, ref_model(f3, a, b));
            if ($urandom_range(0, 1) == 1) idle(1);
        end
        idle(5);
        check("scoreboard_empty", W'(exp_q.size()), W'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
